st_issue_buffer: RTL
====================

ST_ISSUE_BUFFER -- requirements
Module: st_issue_buffer

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration.
REQ-002 SHALL have parameter DEPTH, default 2, number of store-request entries (power of two, 2..8).
REQ-003 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  in  1  discard all held and incoming requests.
REQ-006 SHALL have port valid_i  in  1  issue stage presents a store/AMO request.
REQ-007 SHALL have port lsu_ctrl_i  in  lsu_ctrl_t  request payload.
REQ-008 SHALL have port ready_o  out  1  buffer accepts valid_i this cycle.
REQ-009 SHALL have port valid_o  out  1  head request presented to the store unit.
REQ-010 SHALL have port lsu_ctrl_o  out  lsu_ctrl_t  head request payload.
REQ-011 SHALL have port pop_i  in  1  store unit consumed head (driven by its pop_st_o).
REQ-012 SHALL have port empty_o  out  1  no entries held.
REQ-013 SHALL have port usage_o  out  $clog2(DEPTH)+1  entries held.

Function
REQ-014 SHALL be a circular FIFO with read pointer, write pointer (each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0) and count register (0..DEPTH).
REQ-015 SHALL drive ready_o = (count != DEPTH), independent of pop_i (no combinational pop-to-ready path).
REQ-016 SHALL write entry at write pointer and advance it when valid_i && ready_o && !flush_i (and not bypassed per REQ-027).
REQ-017 SHALL ignore valid_i while ready_o is 0; payload SHALL not be stored and no state SHALL change.
REQ-018 SHALL drive valid_o = (count != 0) and lsu_ctrl_o = entry at read pointer; push-to-valid_o latency one cycle.
REQ-019 SHALL advance read pointer on pop_i && valid_o; pop_i with valid_o 0 SHALL be ignored.
REQ-020 SHALL on simultaneous accepted push and pop keep count unchanged and advance both pointers, including when count == DEPTH-1 or when pointers wrap.
REQ-021 SHALL on flush_i reset both pointers and count to 0 at the next edge, overriding any push or pop in that cycle; valid_o SHALL be 0 the cycle after.
REQ-022 SHALL preserve request order exactly; no entry SHALL be dropped or duplicated absent flush_i.
REQ-023 SHALL drive empty_o = (count == 0), usage_o = count.

Reset
REQ-024 SHALL on rst_ni low asynchronously clear pointers and count; valid_o=0, empty_o=1, usage_o=0, ready_o=1.
REQ-025 SHALL reset entry storage to '0 so lsu_ctrl_o reads '0 after reset.
REQ-026 SHALL, when reset asserts mid-operation, lose all held entries with no partial state after release.

Configuration
REQ-027 With ST_ISSUE_BUFFER_BYPASS_EN defined: when count == 0 and valid_i && !flush_i, valid_o=1 and lsu_ctrl_o=lsu_ctrl_i combinationally; if pop_i that cycle, entry SHALL not be written, else written normally.
REQ-028 Without ST_ISSUE_BUFFER_BYPASS_EN: no bypass path; valid_o purely registered per REQ-018.

Structure
REQ-029 SHALL take lsu_ctrl_t from ariane_pkg; no new package types; DEPTH-derived widths local.
REQ-030 SHALL be a single module with no sub-modules (FIFO logic inline).

Verification
REQ-031 Reset, no bypass: push A cycle 0 -> valid_o=1, lsu_ctrl_o=A cycle 1; pop_i cycle 1 -> empty_o=1, usage_o=0 cycle 2.
REQ-032 DEPTH=2: push A,B, no pop -> ready_o=0, usage_o=2; push C held 3 cycles -> C never stored; pop -> ready_o=1 next cycle, C accepted, order A,B,C.
REQ-033 count=1 steady push+pop 10 cycles -> usage_o stays 1, pointers wrap, 10 payloads out in order.
REQ-034 usage_o=2, flush_i with valid_i and pop_i same cycle -> next cycle usage_o=0, valid_o=0, incoming not stored.
REQ-035 BYPASS_EN, empty, push A with pop_i same cycle -> valid_o=1, lsu_ctrl_o=A that cycle; next cycle empty_o=1.
REQ-036 rst_ni low while usage_o=2 -> immediately valid_o=0, usage_o=0, lsu_ctrl_o='0.

Source files
------------

// File: rtl/ariane_pkg.sv
// Minimal core package: provides the load/store control payload carried by
// the store issue buffer.
package ariane_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] vaddr;
        logic        overflow;
        logic [63:0] data;
        logic [7:0]  be;
        logic [3:0]  fu;
        logic [7:0]  operation;
        logic [2:0]  trans_id;
    } lsu_ctrl_t;

endpackage

// File: rtl/config_pkg.sv
// Minimal core-configuration package: only the configuration type and its
// empty default that st_issue_buffer takes as a parameter.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        logic        RVA;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/st_issue_buffer_pkg.sv
// Helpers shared by the store issue buffer; holds no payload types, the
// payload comes from ariane_pkg.
package st_issue_buffer_pkg;

    // Pointer width for a power-of-two depth, never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/st_issue_buffer.sv
// st_issue_buffer: in-order circular FIFO between issue and the store unit.
// Optional empty-buffer bypass is enabled by defining ST_ISSUE_BUFFER_BYPASS_EN.
module st_issue_buffer
    import ariane_pkg::*;
    import st_issue_buffer_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  lsu_ctrl_t                lsu_ctrl_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output lsu_ctrl_t                lsu_ctrl_o,
    input  logic                     pop_i,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   usage_o
);

    localparam int unsigned     PtrW    = ptr_width(DEPTH);
    localparam int unsigned     CntW    = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    lsu_ctrl_t       mem_q [DEPTH];
    lsu_ctrl_t       mem_d [DEPTH];
    logic            push;
    logic            pop;

    logic unused_cfg;
    assign unused_cfg = ^CVA6Cfg;

    // Outputs depend on registered state only, except for the optional bypass.
    always_comb begin
        ready_o = (count_q != CntFull);
        empty_o = (count_q == '0);
        usage_o = count_q;
        pop     = pop_i && !empty_o;
`ifdef ST_ISSUE_BUFFER_BYPASS_EN
        valid_o    = !empty_o || (valid_i && !flush_i);
        lsu_ctrl_o = empty_o ? lsu_ctrl_i : mem_q[rd_ptr_q];
        // A request consumed straight through the bypass is never written.
        push       = valid_i && ready_o && !flush_i && !(empty_o && pop_i);
`else
        valid_o    = !empty_o;
        lsu_ctrl_o = mem_q[rd_ptr_q];
        push       = valid_i && ready_o && !flush_i;
`endif
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = lsu_ctrl_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule
